afe_serial_prog: RTL and testbench

AFE_SERIAL_PROG -- requirements
Module: afe_serial_prog

---
 rtl/afe_serial_prog.sv | 237 +++++++++++++++++++++++
 tb/tb_afe_serial_prog.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afe_serial_prog.sv
// afe_serial_prog: programs the AFE gain and offset registers over a 3-wire
// serial link (sclk / sdata / active-low sload). The current settings are
// compared with shadow copies of the last values sent, and a 16-bit frame
// {1'b0, addr[2:0], 3'b000, data[8:0]} goes out MSB first for each mismatch.
// Gain is sent before offset.
//
// Frame timing, in SCLK half-periods of SCLK_DIV clocks each:
//   LOAD  : 1 half  (sload low, sclk low, sdata = bit 15)
//   SHIFT : 32 halves, 16 x (sclk high, sclk low). sdata moves to the next
//           bit on each falling edge. On the falling edge after the 16th high
//           half, sload rises and sdata returns to 0; that last low half
//           closes the frame.
//   GAP   : 2 halves (sload high, sclk low)
// The total is 35 half-periods. GAP goes straight to LOAD if a write is
// still pending.
//
// Optional feature macro AFE_SCAN_GATE_EN: when defined, scan_en is held low
// while a write is busy or pending. When undefined, scan_en is cont_en
// delayed by one cycle.
module afe_serial_prog #(
  parameter int unsigned SCLK_DIV  = 5,
  parameter logic [2:0]  GAIN_ADDR = 3'd2,
  parameter logic [2:0]  OFF_ADDR  = 3'd5
) (
  input  logic        clk_100M,
  input  logic        nrst,
  input  logic        cont_en,
  input  logic [15:0] cont_gain,
  input  logic [15:0] cont_off,
  output logic        afe_sclk,
  output logic        afe_sdata,
  output logic        afe_sload,
  output logic        scan_en,
  output logic        afe_busy,
  output logic        cfg_done
);

  localparam int unsigned HP_W    = 8;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned DATA_W  = 9;
  localparam int unsigned FRAME_W = 16;

  localparam logic [HP_W-1:0]   HP_LAST    = HP_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_W - 1);
  localparam logic [DATA_W-1:0] SHADOW_RST = {DATA_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [HP_W-1:0]      hp_cnt_q, hp_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 phase_q, phase_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]    sent_gain_q, sent_gain_d;
  logic [DATA_W-1:0]    sent_off_q, sent_off_d;
  logic                 sclk_q, sclk_d;
  logic                 sdata_q, sdata_d;
  logic                 sload_q, sload_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 scan_en_q, scan_en_d;

  logic                 pend_gain_c;
  logic                 pend_off_c;
  logic                 pend_any_c;
  logic                 hp_end_c;
  logic                 start_frame_c;
  logic [FRAME_W-1:0]   frame_c;
  logic                 unused_upper;

  // Only bits [8:0] of the settings are used.
  assign unused_upper = ^{cont_gain[15:9], cont_off[15:9]};

  // Pending-write detection against the shadow copies of the last sent values.
  assign pend_gain_c = (cont_gain[DATA_W-1:0] != sent_gain_q);
  assign pend_off_c  = (cont_off[DATA_W-1:0]  != sent_off_q);
  assign pend_any_c  = pend_gain_c | pend_off_c;
  assign hp_end_c    = (hp_cnt_q == HP_LAST);

  // Frame to launch next: gain takes priority over offset.
  assign frame_c = pend_gain_c ? {1'b0, GAIN_ADDR, 3'b000, cont_gain[DATA_W-1:0]}
                               : {1'b0, OFF_ADDR,  3'b000, cont_off[DATA_W-1:0]};

  // Scan enable: plain one-cycle delay, or gated by write activity.
`ifdef AFE_SCAN_GATE_EN
  assign scan_en_d = cont_en & ~busy_q & ~pend_gain_c & ~pend_off_c;
`else
  assign scan_en_d = cont_en;
`endif

  // Next-state, serial-line and shadow-register logic.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    phase_d       = phase_q;
    shift_d       = shift_q;
    sent_gain_d   = sent_gain_q;
    sent_off_d    = sent_off_q;
    sclk_d        = sclk_q;
    sdata_d       = sdata_q;
    sload_d       = sload_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    start_frame_c = 1'b0;

    // Half-period counter: held at zero in IDLE, so LOAD always starts at 0.
    if ((state_q == IDLE) || hp_end_c) begin
      hp_cnt_d = '0;
    end else begin
      hp_cnt_d = hp_cnt_q + HP_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (pend_any_c) begin
          start_frame_c = 1'b1;
        end
      end

      LOAD: begin
        if (hp_end_c) begin
          state_d   = SHIFT;
          phase_d   = 1'b0;
          bit_cnt_d = '0;
          sclk_d    = 1'b1;
        end
      end

      SHIFT: begin
        if (hp_end_c) begin
          if (!phase_q) begin
            // Falling edge: present the next bit, or close the frame.
            phase_d = 1'b1;
            sclk_d  = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              sload_d = 1'b1;
              sdata_d = 1'b0;
            end else begin
              sdata_d = shift_q[FRAME_W-2];
              shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
          end else if (bit_cnt_q == BIT_LAST) begin
            state_d = GAP;
            phase_d = 1'b0;
          end else begin
            // Rising edge: the AFE samples the bit now on sdata.
            phase_d   = 1'b0;
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      GAP: begin
        if (hp_end_c) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (pend_any_c) begin
            start_frame_c = 1'b1;
          end else begin
            state_d = IDLE;
            phase_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Frame launch: capture the frame and update the matching shadow register.
    if (start_frame_c) begin
      state_d   = LOAD;
      phase_d   = 1'b0;
      bit_cnt_d = '0;
      sclk_d    = 1'b0;
      sload_d   = 1'b0;
      busy_d    = 1'b1;
      shift_d   = frame_c;
      sdata_d   = frame_c[FRAME_W-1];
      if (pend_gain_c) begin
        sent_gain_d = cont_gain[DATA_W-1:0];
      end else begin
        sent_off_d = cont_off[DATA_W-1:0];
      end
    end
  end

  // State and output registers. Reset aborts any frame with sload high.
  always_ff @(posedge clk_100M or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      hp_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      phase_q     <= 1'b0;
      shift_q     <= '0;
      sent_gain_q <= SHADOW_RST;
      sent_off_q  <= SHADOW_RST;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      sload_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      scan_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_cnt_q    <= hp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      sent_gain_q <= sent_gain_d;
      sent_off_q  <= sent_off_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      sload_q     <= sload_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      scan_en_q   <= scan_en_d;
    end
  end

  assign afe_sclk  = sclk_q;
  assign afe_sdata = sdata_q;
  assign afe_sload = sload_q;
  assign afe_busy  = busy_q;
  assign cfg_done  = done_q;
  assign scan_en   = scan_en_q;

endmodule

// File: tb/tb_afe_serial_prog.sv
// Bench for afe_serial_prog: a serial-bus monitor decodes the frames seen on
// sclk/sdata/sload, and a shadow-value model predicts which frames must
// appear for each settings change.
module tb_afe_serial_prog;

  localparam int unsigned SCLK_DIV  = 5;
  localparam logic [2:0]  GA        = 3'd2;
  localparam logic [2:0]  OA        = 3'd5;
  localparam int          FRAME_CYC = 35 * SCLK_DIV;

  logic        clk_100M = 1'b0;
  logic        nrst     = 1'b0;
  logic        cont_en  = 1'b0;
  logic [15:0] cont_gain = 16'h0123;
  logic [15:0] cont_off  = 16'h0045;
  logic        afe_sclk, afe_sdata, afe_sload, scan_en, afe_busy, cfg_done;

  afe_serial_prog #(.SCLK_DIV(SCLK_DIV), .GAIN_ADDR(GA), .OFF_ADDR(OA)) dut (
    .clk_100M  (clk_100M),
    .nrst      (nrst),
    .cont_en   (cont_en),
    .cont_gain (cont_gain),
    .cont_off  (cont_off),
    .afe_sclk  (afe_sclk),
    .afe_sdata (afe_sdata),
    .afe_sload (afe_sload),
    .scan_en   (scan_en),
    .afe_busy  (afe_busy),
    .cfg_done  (cfg_done)
  );

  always #5 clk_100M = ~clk_100M;

`ifdef AFE_SCAN_GATE_EN
  localparam logic SCAN_DURING_WRITE = 1'b0;
`else
  localparam logic SCAN_DURING_WRITE = 1'b1;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: last value the AFE should hold for each register.
  logic [8:0]  m_sent_gain = 9'h1FF;
  logic [8:0]  m_sent_off  = 9'h1FF;
  logic [15:0] exp_q[$];

  // Bus monitor results.
  logic [15:0] frames_q[$];
  int          nbits_q[$];
  int          len_q[$];
  int          cyc = 0, start_cyc = 0, bits = 0, done_cnt = 0, hi_len = 0;
  int          bad_hi = 0, bad_line = 0, bad_done_w = 0;
  bit          in_frame = 0, have_start = 0;
  bit          p_sclk = 0, p_sload = 1, p_busy = 0, p_done = 0;
  logic [15:0] shreg = '0;

  typedef struct {
    logic [15:0] gain;
    logic [15:0] off;
    int          n;
    logic [15:0] f0;
    logic [15:0] f1;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [15:0] mkframe(logic [2:0] a, logic [8:0] d);
    return {1'b0, a, 3'b000, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Serial bus monitor, sampling between clock edges.
  initial begin
    forever begin
      @(negedge clk_100M);
      cyc++;
      if (!nrst) begin
        in_frame = 0; have_start = 0; bits = 0; hi_len = 0;
        p_sclk = 0; p_sload = 1; p_busy = 0; p_done = 0;
      end else begin
        if (p_busy && !afe_busy && have_start) begin
          len_q.push_back(cyc - start_cyc);
          have_start = 0;
        end
        if (p_sload && !afe_sload) begin
          if (have_start) len_q.push_back(cyc - start_cyc);
          start_cyc = cyc; have_start = 1; in_frame = 1; shreg = '0; bits = 0;
        end
        if (!p_sclk && afe_sclk && !afe_sload) begin
          shreg = {shreg[14:0], afe_sdata};
          bits++;
        end
        if (!p_sload && afe_sload && in_frame) begin
          frames_q.push_back(shreg);
          nbits_q.push_back(bits);
          in_frame = 0; bits = 0;
        end
        if (afe_sclk) hi_len++;
        if (p_sclk && !afe_sclk) begin
          if (hi_len != SCLK_DIV) bad_hi++;
          hi_len = 0;
        end
        if (afe_sclk && afe_sload) bad_line++;
        if (!afe_sload && !afe_busy) bad_line++;
        if (cfg_done) done_cnt++;
        if (cfg_done && p_done) bad_done_w++;
        p_sclk = afe_sclk; p_sload = afe_sload; p_busy = afe_busy; p_done = cfg_done;
      end
    end
  end

  // Predict frames for the current inputs against the model shadows.
  task automatic model_expect();
    if (cont_gain[8:0] != m_sent_gain) begin
      exp_q.push_back(mkframe(GA, cont_gain[8:0]));
      m_sent_gain = cont_gain[8:0];
    end
    if (cont_off[8:0] != m_sent_off) begin
      exp_q.push_back(mkframe(OA, cont_off[8:0]));
      m_sent_off = cont_off[8:0];
    end
  endtask

  task automatic apply(input logic [15:0] g, input logic [15:0] o);
    @(negedge clk_100M);
    cont_gain = g;
    cont_off  = o;
    model_expect();
  endtask

  task automatic wait_bits(input int k);
    int n;
    n = 0;
    while (bits < k && n < 2 * FRAME_CYC) begin
      @(posedge clk_100M);
      n++;
    end
    chk("wait_bits_reached", 32'(bits >= k), 32'd1);
  endtask

  task automatic wait_done(input int max);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < max) begin
      @(posedge clk_100M);
      n++;
    end
    chk("cfg_done_pulses", 32'(done_cnt - d0), 32'd1);
    repeat (3) @(posedge clk_100M);
  endtask

  task automatic compare_frames();
    chk("frame_count", 32'(frames_q.size()), 32'(exp_q.size()));
    chk("len_count", 32'(len_q.size()), 32'(frames_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < frames_q.size()) begin
        chk($sformatf("frame%0d", i), 32'(frames_q[i]), 32'(exp_q[i]));
        chk("frame_bits", 32'(nbits_q[i]), 32'd16);
      end
      if (i < len_q.size()) chk("frame_len", 32'(len_q[i]), 32'(FRAME_CYC));
    end
    frames_q.delete(); nbits_q.delete(); len_q.delete(); exp_q.delete();
  endtask

  task automatic settle();
    int d0;
    if (exp_q.size() > 0) begin
      wait_done(exp_q.size() * FRAME_CYC + 50);
    end else begin
      d0 = done_cnt;
      repeat (2 * FRAME_CYC) @(posedge clk_100M);
      chk("no_cfg_done", 32'(done_cnt - d0), 32'd0);
    end
    compare_frames();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h0010, 16'h0045, 1, 16'h2010, 16'h0000};
    tbl[1] = '{16'h0010, 16'h0045, 0, 16'h0000, 16'h0000};
    tbl[2] = '{16'hFE10, 16'h8045, 0, 16'h0000, 16'h0000};
    tbl[3] = '{16'h01FF, 16'h0100, 2, 16'h21FF, 16'h5100};
    tbl[4] = '{16'h0000, 16'h0000, 2, 16'h2000, 16'h5000};
    tbl[5] = '{16'h0000, 16'h01AB, 1, 16'h51AB, 16'h0000};

    // Reset values.
    repeat (3) @(negedge clk_100M);
    chk("rst_sclk", 32'(afe_sclk), 32'd0);
    chk("rst_sdata", 32'(afe_sdata), 32'd0);
    chk("rst_sload", 32'(afe_sload), 32'd1);
    chk("rst_scan_en", 32'(scan_en), 32'd0);
    chk("rst_busy", 32'(afe_busy), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);

    // Both writes forced after reset, gain first.
    @(negedge clk_100M);
    nrst = 1'b1;
    exp_q.push_back(16'h2123);
    exp_q.push_back(16'h5045);
    m_sent_gain = 9'h123; m_sent_off = 9'h045;
    settle();

    // Table of settings changes applied from idle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_100M);
      cont_gain = tbl[i].gain;
      cont_off  = tbl[i].off;
      if (tbl[i].n > 0) exp_q.push_back(tbl[i].f0);
      if (tbl[i].n > 1) exp_q.push_back(tbl[i].f1);
      m_sent_gain = tbl[i].gain[8:0];
      m_sent_off  = tbl[i].off[8:0];
      settle();
    end

    // Offset changed mid gain-frame: gain frame intact, then offset frame.
    apply(16'h0055, cont_off);
    wait_bits(8);
    @(negedge clk_100M);
    cont_off = 16'h0033;
    model_expect();
    settle();

    // Gain changed and restored while an offset frame is in flight: no gain write.
    apply(16'h0055, 16'h0077);
    wait_bits(3);
    @(negedge clk_100M);
    cont_gain = 16'h0099;
    wait_bits(10);
    @(negedge clk_100M);
    cont_gain = 16'h0055;
    settle();

    // Reset during bit 5 aborts the frame; both registers are rewritten.
    apply(16'h0066, cont_off);
    wait_bits(5);
    @(negedge clk_100M);
    nrst = 1'b0;
    #1;
    chk("abort_sload", 32'(afe_sload), 32'd1);
    chk("abort_sclk", 32'(afe_sclk), 32'd0);
    repeat (3) @(negedge clk_100M);
    chk("abort_busy", 32'(afe_busy), 32'd0);
    frames_q.delete(); nbits_q.delete(); len_q.delete(); exp_q.delete();
    m_sent_gain = 9'h1FF; m_sent_off = 9'h1FF;
    nrst = 1'b1;
    model_expect();
    settle();

    // Reset with gain equal to the reset shadow value: only offset is written.
    @(negedge clk_100M);
    nrst = 1'b0;
    cont_gain = 16'h11FF;
    repeat (2) @(negedge clk_100M);
    nrst = 1'b1;
    m_sent_gain = 9'h1FF; m_sent_off = 9'h1FF;
    model_expect();
    settle();

    // scan_en latency and behaviour during a write.
    @(negedge clk_100M);
    cont_en = 1'b1;
    repeat (2) @(negedge clk_100M);
    chk("scan_en_idle", 32'(scan_en), 32'd1);
    cont_en = 1'b0;
    chk("scan_en_hold", 32'(scan_en), 32'd1);
    @(negedge clk_100M);
    chk("scan_en_latency", 32'(scan_en), 32'd0);
    cont_en = 1'b1;
    @(negedge clk_100M);
    chk("scan_en_rise", 32'(scan_en), 32'd1);
    apply(16'h0011, cont_off);
    wait_bits(4);
    chk("scan_en_write", 32'(scan_en), 32'(SCAN_DURING_WRITE));
    begin
      int n;
      n = 0;
      while (!cfg_done && n < 2 * FRAME_CYC) begin
        @(negedge clk_100M);
        n++;
      end
      chk("scan_done_seen", 32'(cfg_done), 32'd1);
      chk("scan_en_at_idle", 32'(scan_en), 32'(SCAN_DURING_WRITE));
      @(negedge clk_100M);
      chk("scan_en_after_idle", 32'(scan_en), 32'd1);
    end
    repeat (3) @(posedge clk_100M);
    compare_frames();

    // Randomized settings changes against the model.
    for (int it = 0; it < 12; it++) begin
      logic [15:0] g, o;
      logic [1:0]  r;
      g = cont_gain;
      o = cont_off;
      r = 2'($urandom_range(0, 3));
      if (r[0]) g = 16'($urandom);
      if (r[1]) o = 16'($urandom);
      if ($urandom_range(0, 7) == 0) g[8:0] = 9'h1FF;
      if ($urandom_range(0, 7) == 0) o[8:0] = m_sent_off;
      apply(g, o);
      settle();
    end

    chk("sclk_high_width_errs", 32'(bad_hi), 32'd0);
    chk("line_level_errs", 32'(bad_line), 32'd0);
    chk("cfg_done_width_errs", 32'(bad_done_w), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
